// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with glitch-free shadowed ratio/duty updates
// Odd ratios in 50 % mode borrow a falling-edge copy of the high phase to stretch it by half a cycle.
module clk_div_prog #(
  parameter int W        = 8,
  parameter int DEF_DIV  = 8,
  parameter int DEF_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         div_load,
  input  logic [W-1:0] div_val,
  input  logic         div_mode,
  output logic         clk_div,
  output logic         tick,
  output logic         pending,
  output logic         cfg_err
);

  localparam logic [W-1:0] DEF_N = W'(DEF_DIV);
  localparam logic         DEF_M = (DEF_MODE != 0);

  logic [W-1:0] n_act_q, n_act_d;
  logic [W-1:0] n_shd_q, n_shd_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         mode_act_q, mode_act_d;
  logic         mode_shd_q, mode_shd_d;
  logic         pending_q, pending_d;
  logic         pos_q, pos_d;
  logic         neg_q, neg_d;
  logic         tick_q, tick_d;
  logic         cfg_err_q, cfg_err_d;

  logic [W-1:0] cnt_nx, n_eff, half;
  logic         wrap, apply, load_ok, mode_eff;

  always_comb begin
    cnt_nx   = (cnt_q == n_act_q - W'(1)) ? '0 : cnt_q + W'(1);
    wrap     = en && (cnt_nx == '0);
    // A pending config lands on a period boundary, or immediately while stopped.
    apply    = pending_q && (wrap || !en);
    load_ok  = div_load && (div_val >= W'(2));
    n_eff    = apply ? n_shd_q : n_act_q;
    mode_eff = apply ? mode_shd_q : mode_act_q;
    half     = n_eff >> 1;

    n_act_d    = n_eff;
    mode_act_d = mode_eff;
    n_shd_d    = load_ok ? div_val : n_shd_q;
    mode_shd_d = load_ok ? div_mode : mode_shd_q;
    pending_d  = load_ok || (pending_q && !apply);
    cfg_err_d  = div_load && !load_ok;
    tick_d     = wrap;
    neg_d      = pos_q;

    if (en) begin
      cnt_d = cnt_nx;
      pos_d = mode_eff ? (cnt_nx == '0) : (cnt_nx < half);
    end else begin
      // Parking at n-1 makes the first enabled edge start a fresh period.
      cnt_d = n_eff - W'(1);
      pos_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_act_q    <= DEF_N;
      n_shd_q    <= DEF_N;
      mode_act_q <= DEF_M;
      mode_shd_q <= DEF_M;
      cnt_q      <= DEF_N - W'(1);
      pending_q  <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      n_act_q    <= n_act_d;
      n_shd_q    <= n_shd_d;
      mode_act_q <= mode_act_d;
      mode_shd_q <= mode_shd_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  assign clk_div = (!mode_act_q && n_act_q[0]) ? (pos_q | neg_q) : pos_q;
  assign tick    = tick_q;
  assign pending = pending_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - randomized and directed checks of clk_div_prog against a phase-position model
module tb_clk_div_prog;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_mode = 1'b0;
  logic         clk_div, tick, pending, cfg_err;

  clk_div_prog #(.W(W), .DEF_DIV(8), .DEF_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_load(div_load), .div_val(div_val),
    .div_mode(div_mode), .clk_div(clk_div), .tick(tick), .pending(pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference: position k within the current period; k = -1 means "next enabled edge starts a period".
  int m_n, m_mode, m_shd, m_mshd, m_pend, m_k, m_err, m_en;
  // Bit order: {clk_div first half, tick, pending, cfg_err, clk_div second half}
  logic [4:0] obs, expv, msk;

  task automatic model_reset();
    m_n = 8; m_mode = 0; m_shd = 8; m_mshd = 0; m_pend = 0; m_k = -1; m_err = 0; m_en = 0;
  endtask

  task automatic model_apply();
    m_n = m_shd; m_mode = m_mshd; m_pend = 0;
  endtask

  task automatic step();
    int h;
    @(posedge clk);
    m_err = 0;
    if (en) begin
      if (m_k < 0 || m_k >= m_n - 1) begin
        m_k = 0;
        if (m_pend != 0) model_apply();
      end else begin
        m_k++;
      end
    end else begin
      m_k = -1;
      if (m_pend != 0) model_apply();
    end
    if (div_load) begin
      if (int'(div_val) < 2) m_err = 1;
      else begin m_shd = int'(div_val); m_mshd = int'(div_mode); m_pend = 1; end
    end
    m_en = int'(en);
    h = m_n / 2;
    #1;
    obs[4:1] = {clk_div, tick, pending, cfg_err};
    if (m_en != 0) begin
      expv[4] = (m_mode != 0) ? (m_k == 0) : (m_k < h || ((m_n % 2) == 1 && m_k == h));
      msk[4]  = 1'b1;
    end else begin
      // Stopping only promises clk_div low by the next falling edge.
      expv[4] = 1'b0;
      msk[4]  = 1'b0;
    end
    expv[3] = (m_en != 0) && (m_k == 0);
    expv[2] = (m_pend != 0);
    expv[1] = (m_err != 0);
    msk[3:1] = 3'b111;
    @(negedge clk);
    #1;
    obs[0]  = clk_div;
    expv[0] = (m_en != 0) && ((m_mode != 0) ? (m_k == 0) : (m_k < h));
    msk[0]  = 1'b1;
  endtask

  task automatic load(input int val, input logic mode);
    div_load = 1'b1; div_val = W'(val); div_mode = mode;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (clk_div !== 1'b0) begin mismatched++; $display("FAIL reset_clk_div got=%b want=0", clk_div); end
    compared++;
    if (tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick got=%b want=0", tick); end
    compared++;
    if (pending !== 1'b0) begin mismatched++; $display("FAIL reset_pending got=%b want=0", pending); end
    compared++;
    if (cfg_err !== 1'b0) begin mismatched++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_default();
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(); compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL default i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_odd_load();
    load(5, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(); div_load = 1'b0; compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL odd5 i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_pulse_mode();
    load(3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(); div_load = 1'b0; compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL pulse3 i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_cfg_err();
    int errs;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) load(1, 1'b0);
      else if (i == 1) load(0, 1'b1);
      else div_load = 1'b0;
      step(); errs += int'(obs[1]); compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL cfg_err i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
    compared++;
    if (errs !== 2) begin mismatched++; $display("FAIL cfg_err_count got=%0d want=2", errs); end
  endtask

  task automatic test_overwrite();
    int guard;
    guard = 0;
    while (m_k != 0 && guard < 50) begin step(); guard++; end
    for (int i = 0; i < 30; i++) begin
      if (i == 0) load(6, 1'b0);
      else if (i == 1) load(10, 1'b0);
      else div_load = 1'b0;
      step(); compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL overwrite i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
    guard = 0;
    while (m_k != m_n - 1 && guard < 50) begin step(); guard++; end
    load(4, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(); div_load = 1'b0; compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL load_at_wrap i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_enable();
    load(7, 1'b0);
    for (int i = 0; i < 40; i++) begin
      en = !(i >= 10 && i < 16);
      if (i == 12) load(5, 1'b0);
      step(); div_load = 1'b0; compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL enable i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (m_k != 0 && guard < 50) begin step(); guard++; end
    load(9, 1'b0);
    step(); div_load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (clk_div !== 1'b0) begin mismatched++; $display("FAIL async_reset_clk_div got=%b want=0", clk_div); end
    compared++;
    if (pending !== 1'b0) begin mismatched++; $display("FAIL async_reset_pending got=%b want=0", pending); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL after_reset i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom % 16) != 0;
      div_load = ($urandom % 6) == 0;
      div_val  = W'($urandom_range(0, 20));
      div_mode = $urandom % 2;
      step(); compared++;
      if ((obs & msk) !== expv) begin
        mismatched++; $display("FAIL random i=%0d got=%b want=%b", i, obs & msk, expv);
      end
    end
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_odd_load();
    test_pulse_mode();
    test_cfg_err();
    test_overwrite();
    test_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
